ftm_buffer_writer: RTL and testbench
====================================

Name: ftm_buffer_writer

Overview:
- Upstream fill stage for the feature-map (ftm) banked buffer.
- Accepts a DDR-sourced AXI-Stream of ftm words and scatters them into N_BUF_X column-interleaved BRAM banks.
- Uses the layout the downstream ftm buffer reader expects: bank = x mod N_BUF_X, address = n_wrap_c*(y + h*floor(x/N_BUF_X)) + cw.
- One stream beat is one DATA_WIDTH channel-chunk (64 channels) of one pixel.

Parameters:
- N_BUF_X, 5, number of column-interleaved banks.
- B_BUF_ADDR, 9, bank address width.
- B_SHAPE, 32, packed shape word width.
- B_COORD, 10, x/y counter width.
- DATA_WIDTH, 64, stream and bank data width.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- ftm_shape  in  B_SHAPE  packed shape: c=[31:20], h=[19:10], w=[9:0].
- start  in  1  one-cycle request to load one feature map.
- s_axis_tdata  in  DATA_WIDTH  stream data.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready.
- wraddr  out  B_BUF_ADDR*N_BUF_X  per-bank write address; bank i at [i*B_BUF_ADDR +: B_BUF_ADDR].
- wrdata  out  DATA_WIDTH  write data, broadcast to all banks.
- wren  out  N_BUF_X  per-bank write enable, one-hot or zero.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: rstn is synchronous, active-low; clock is clk.
  - On reset: state=IDLE; all counters 0; s_axis_tready=0, wraddr=0, wrdata=0, wren=0, busy=0, done=0.
  - Reset mid-transfer aborts immediately; no further wren; partial bank contents undefined.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - tready=0.
  - On start=1: latch h, w and n_wrap_c = c>>6 (12-bit c, so n_wrap_c 0..63); clear cw, x, rx, qx, y.
  - If n_wrap_c==0, h==0 or w==0: go to DONE (zero writes). Otherwise go to LOAD.
- LOAD:
  - tready=1 (combinational from state); busy=1.
  - A beat is accepted when tvalid && tready. Cycles with tvalid=0 hold all counters and produce wren=0.
  - Beat order, innermost first: cw in [0, n_wrap_c), then x in [0, w), then y in [0, h).
  - Per accepted beat in cycle k, registered outputs in cycle k+1:
    - wren[rx]=1, all other wren bits 0.
    - wraddr of bank rx = n_wrap_c*(y + h*qx) + cw, truncated to B_BUF_ADDR; all other bank addresses 0.
    - wrdata = tdata.
  - Counter advance:
    - cw++. At cw==n_wrap_c-1: cw=0 and x++.
    - On each x++: rx++; at rx==N_BUF_X-1, rx=0 and qx++.
    - At x==w-1 (end of row): x=0, rx=0, qx=0, y++.
    - Final beat (y==h-1, x==w-1, cw==n_wrap_c-1): next state DONE, tready drops next cycle.
  - The address product may be computed incrementally or with a multiplier; the result must be bit-identical to the formula. No capacity check is performed; overflow wraps modulo 2^B_BUF_ADDR.
- DONE:
  - done=1 for exactly one cycle, in the same cycle as the final beat's wren.
  - busy=0 in this cycle; return to IDLE.
- Total accepted beats = h*w*n_wrap_c exactly; tready is never high in IDLE or DONE.
- start while in LOAD or DONE is ignored.
- ftm_shape is sampled only at an accepted start; later changes have no effect.

Test Plan:
- Nominal layout: shape c=128, h=2, w=6 (n_wrap=2), N_BUF_X=5; 24 beats, tdata=beat index, tvalid held high.
  - Beats 0-9 -> banks 0..4, addrs {0,1} each.
  - Beats 10,11 (x=5) -> bank0 addrs 4,5.
  - Row y=1 -> banks 0..4 addrs {2,3}; x=5 -> bank0 addrs 6,7.
  - done pulses with the 24th wren; exactly 24 wren cycles.
- Backpressure-free gaps: same shape, tvalid toggled 1,0,0,1,... -> identical write sequence; wren=0 on gap cycles; counters held.
- Degenerate shape: start with c=32 (n_wrap=0) -> done pulses 1 cycle after leaving IDLE; tready never 1; no wren.
- Ignored start: start pulsed during LOAD with a different shape -> sequence unchanged; exactly one done.
- Reset mid-transfer: rstn=0 after beat 7 -> next cycle all outputs 0, state IDLE. A fresh start then restarts at bank0 addr 0.
- Address wrap: c=4032 (n_wrap=63), h=8, w=10 -> bank0 qx=1 first address = 63*8 = 504; later addresses truncate modulo 512.

Source files
------------

// File: rtl/ftm_buffer_writer.sv
// Feature-map buffer fill stage: scatters a channel-chunked pixel stream
// into N_BUF_X column-interleaved banks in the layout the reader expects.
module ftm_buffer_writer #(
  parameter int N_BUF_X    = 5,
  parameter int B_BUF_ADDR = 9,
  parameter int B_SHAPE    = 32,
  parameter int B_COORD    = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [B_SHAPE-1:0]            ftm_shape,
  input  logic                          start,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [B_BUF_ADDR*N_BUF_X-1:0] wraddr,
  output logic [DATA_WIDTH-1:0]         wrdata,
  output logic [N_BUF_X-1:0]            wren,
  output logic                          busy,
  output logic                          done
);

  localparam int B_RX = (N_BUF_X > 1) ? $clog2(N_BUF_X) : 1;
  localparam logic [B_COORD-1:0] ONE_C = 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [5:0]            n_wrap, cw;
  logic [B_COORD-1:0]    h, w, x, qx, y;
  logic [B_RX-1:0]       rx;
  logic                  beat;
  logic                  last_cw, last_x, last_y;
  logic                  shape_zero;
  logic [B_BUF_ADDR-1:0] row_base, addr;
  logic [N_BUF_X-1:0]    wren_nxt;
  logic [B_BUF_ADDR*N_BUF_X-1:0] wraddr_nxt;
  logic                  unused_shape;

  assign unused_shape  = ^ftm_shape[25:20];

  assign s_axis_tready = (state == LOAD);
  assign busy          = (state == LOAD);
  assign done          = (state == DONE);
  assign beat          = s_axis_tvalid & s_axis_tready;

  assign last_cw = (cw == n_wrap - 6'd1);
  assign last_x  = (x == w - ONE_C);
  assign last_y  = (y == h - ONE_C);

  assign shape_zero = (ftm_shape[31:26] == '0) ||
                      (ftm_shape[19:10] == '0) ||
                      (ftm_shape[9:0] == '0);

  // Arithmetic kept at bank-address width: wraps mod 2^B_BUF_ADDR exactly.
  assign row_base = B_BUF_ADDR'(y) +
                    B_BUF_ADDR'(h) * B_BUF_ADDR'(qx);
  assign addr     = B_BUF_ADDR'(n_wrap) * row_base +
                    B_BUF_ADDR'(cw);

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = shape_zero ? DONE : LOAD;
      end
      LOAD: begin
        if (beat && last_cw && last_x && last_y)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      n_wrap <= '0;
      h      <= '0;
      w      <= '0;
      cw     <= '0;
      x      <= '0;
      rx     <= '0;
      qx     <= '0;
      y      <= '0;
    end else if (state == IDLE && start) begin
      n_wrap <= ftm_shape[31:26];
      h      <= ftm_shape[19:10];
      w      <= ftm_shape[9:0];
      cw     <= '0;
      x      <= '0;
      rx     <= '0;
      qx     <= '0;
      y      <= '0;
    end else if (beat) begin
      if (!last_cw) begin
        cw <= cw + 6'd1;
      end else begin
        cw <= '0;
        if (last_x) begin
          x  <= '0;
          rx <= '0;
          qx <= '0;
          y  <= y + ONE_C;
        end else begin
          x <= x + ONE_C;
          if (rx == B_RX'(N_BUF_X - 1)) begin
            rx <= '0;
            qx <= qx + ONE_C;
          end else begin
            rx <= rx + B_RX'(1);
          end
        end
      end
    end
  end

  always_comb begin
    wren_nxt   = '0;
    wraddr_nxt = '0;
    if (beat) begin
      for (int i = 0; i < N_BUF_X; i++) begin
        if (rx == B_RX'(i)) begin
          wren_nxt[i] = 1'b1;
          wraddr_nxt[i*B_BUF_ADDR +: B_BUF_ADDR] = addr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wren   <= '0;
      wraddr <= '0;
      wrdata <= '0;
    end else begin
      wren   <= wren_nxt;
      wraddr <= wraddr_nxt;
      if (beat) wrdata <= s_axis_tdata;
    end
  end

endmodule

// File: tb/tb_ftm_buffer_writer.sv
// Directed bench for ftm_buffer_writer: layout table, gaps, ignored
// start, degenerate shape, mid-transfer reset and address wrap.
module tb_ftm_buffer_writer;

  localparam int N  = 5;
  localparam int BA = 9;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [31:0]     ftm_shape = '0;
  logic            start = 1'b0;
  logic [DW-1:0]   s_axis_tdata = '0;
  logic            s_axis_tvalid = 1'b0;
  logic            s_axis_tready;
  logic [BA*N-1:0] wraddr;
  logic [DW-1:0]   wrdata;
  logic [N-1:0]    wren;
  logic            busy;
  logic            done;

  ftm_buffer_writer dut (
    .clk          (clk),
    .rstn         (rstn),
    .ftm_shape    (ftm_shape),
    .start        (start),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .wraddr       (wraddr),
    .wrdata       (wrdata),
    .wren         (wren),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]    wren;
    logic [BA*N-1:0] wraddr;
    logic [DW-1:0]   data;
    logic            done;
  } rec_t;

  typedef struct {
    int bank;
    int addr;
  } vec_t;

  rec_t q[$];
  rec_t mon_r;
  vec_t tbl[24];
  int   done_cnt = 0;
  int   total = 0;
  int   bad = 0;

  int exp_bank[24] = '{0,0,1,1,2,2,3,3,4,4,0,0,
                       0,0,1,1,2,2,3,3,4,4,0,0};
  int exp_addr[24] = '{0,1,0,1,0,1,0,1,0,1,4,5,
                       2,3,2,3,2,3,2,3,2,3,6,7};

  localparam logic [31:0] SH_NOM  = (32'd128 << 20) | (32'd2 << 10) | 32'd6;
  localparam logic [31:0] SH_ALT  = (32'd64 << 20) | (32'd1 << 10) | 32'd1;
  localparam logic [31:0] SH_DEG  = (32'd32 << 20) | (32'd2 << 10) | 32'd6;
  localparam logic [31:0] SH_WRAP = (32'd4032 << 20) | (32'd8 << 10) | 32'd10;

  always @(negedge clk) begin
    if (wren != '0) begin
      mon_r.wren   = wren;
      mon_r.wraddr = wraddr;
      mon_r.data   = wrdata;
      mon_r.done   = done;
      q.push_back(mon_r);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic check_rec(input string nm, input int i,
                           input int bank, input int addr,
                           input longint data, input bit dn);
    rec_t            r;
    int              gb;
    logic [BA*N-1:0] wa;
    logic [BA*N-1:0] mask;
    if (i >= q.size()) begin
      total++;
      bad++;
      $display("FAIL %s[%0d]: record missing, have %0d want >%0d",
               nm, i, q.size(), i);
    end else begin
      r  = q[i];
      gb = -1;
      for (int b = 0; b < N; b++) if (r.wren[b]) gb = b;
      wa   = r.wraddr;
      mask = (BA*N)'(9'h1ff) << (bank * BA);
      chk($sformatf("%s[%0d].onehot", nm, i), $onehot(r.wren), 1);
      chk($sformatf("%s[%0d].bank", nm, i), gb, bank);
      chk($sformatf("%s[%0d].addr", nm, i),
          (wa >> (bank * BA)) & 45'h1ff, addr);
      chk($sformatf("%s[%0d].others", nm, i),
          (wa & ~mask) != '0, 0);
      chk($sformatf("%s[%0d].data", nm, i), r.data, data);
      chk($sformatf("%s[%0d].done", nm, i), r.done, dn);
    end
  endtask

  task automatic do_start(input logic [31:0] sh);
    @(negedge clk);
    ftm_shape = sh;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    ftm_shape = 32'hffff_ffff;
  endtask

  task automatic stream(input int n, input bit gap, input int inj);
    int sent = 0;
    int cyc  = 0;
    bit acc;
    while (sent < n && cyc < 3 * n + 20) begin
      s_axis_tvalid = gap ? (cyc % 3 == 0) : 1'b1;
      s_axis_tdata  = DW'(sent);
      start         = (cyc == inj);
      if (cyc == inj) ftm_shape = SH_ALT;
      acc = s_axis_tvalid && s_axis_tready;
      @(negedge clk);
      if (acc) sent++;
      cyc++;
    end
    start         = 1'b0;
    s_axis_tvalid = 1'b0;
    chk("stream_beats", sent, n);
  endtask

  task automatic check_nominal(input string nm);
    chk({nm, ".count"}, q.size(), 24);
    for (int i = 0; i < 24; i++)
      check_rec(nm, i, tbl[i].bank, tbl[i].addr, i, i == 23);
    chk({nm, ".done_cnt"}, done_cnt, 1);
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, ".wren"}, wren, 0);
    chk({nm, ".wraddr"}, wraddr != '0, 0);
    chk({nm, ".wrdata"}, wrdata, 0);
    chk({nm, ".tready"}, s_axis_tready, 0);
    chk({nm, ".busy"}, busy, 0);
    chk({nm, ".done"}, done, 0);
  endtask

  task automatic clear_mon();
    q.delete();
    done_cnt = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 24; i++) begin
      tbl[i].bank = exp_bank[i];
      tbl[i].addr = exp_addr[i];
    end

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rstn = 1'b1;

    clear_mon();
    do_start(SH_NOM);
    stream(24, 1'b0, -1);
    repeat (4) @(negedge clk);
    check_nominal("nominal");

    clear_mon();
    do_start(SH_NOM);
    stream(24, 1'b1, -1);
    repeat (4) @(negedge clk);
    check_nominal("gaps");

    clear_mon();
    do_start(SH_NOM);
    stream(24, 1'b0, 5);
    repeat (4) @(negedge clk);
    check_nominal("ign_start");

    clear_mon();
    @(negedge clk);
    ftm_shape = SH_DEG;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    chk("degen.done", done, 1);
    chk("degen.tready", s_axis_tready, 0);
    chk("degen.busy", busy, 0);
    @(negedge clk);
    chk("degen.done_low", done, 0);
    repeat (3) @(negedge clk);
    chk("degen.writes", q.size(), 0);
    chk("degen.done_cnt", done_cnt, 1);

    clear_mon();
    do_start(SH_NOM);
    stream(8, 1'b0, -1);
    rstn = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    rstn = 1'b1;
    chk("midreset.count", q.size(), 8);
    check_rec("midreset", 7, 3, 1, 7, 1'b0);
    chk("midreset.done_cnt", done_cnt, 0);

    clear_mon();
    do_start(SH_NOM);
    stream(24, 1'b0, -1);
    repeat (4) @(negedge clk);
    check_nominal("restart");

    clear_mon();
    do_start(SH_WRAP);
    stream(5040, 1'b0, -1);
    repeat (4) @(negedge clk);
    chk("wrap.count", q.size(), 5040);
    check_rec("wrap", 0, 0, 0, 0, 1'b0);
    check_rec("wrap", 252, 4, 0, 252, 1'b0);
    check_rec("wrap", 315, 0, 504, 315, 1'b0);
    check_rec("wrap", 316, 0, 505, 316, 1'b0);
    check_rec("wrap", 323, 0, 0, 323, 1'b0);
    check_rec("wrap", 630, 0, 63, 630, 1'b0);
    check_rec("wrap", 5039, 4, 495, 5039, 1'b1);
    chk("wrap.done_cnt", done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
